frame_cfg_ctrl: RTL

Frame-synchronous controller for the skin-detection pipeline (rgb2ycbcr -> bin -> centroid -> visualize). It holds the Cb/Cr threshold window used by the binarisation stage. A host writes new thresholds into shadow registers, and they are applied atomically at the next frame boundary, so a frame is never segmented with mixed thresholds. It also captures the centroid result once per frame, counts frames, and optionally checks that each frame carried the expected number of active pixels.

---
 rtl/frame_cfg_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/frame_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// frame_cfg_ctrl
//
// Frame-synchronous control block for the skin-detection pipeline.
// The host writes Cb/Cr thresholds into shadow registers. A commit copies all
// four into the active registers on the cycle after the next vsync rising
// edge, so the bin stage never sees mixed thresholds within one frame. The
// block also latches the centroid result and counts frames at each boundary.
// Optionally, it checks the number of active pixels per frame.
//
// Optional feature macro: FRAME_CFG_CTRL_PIXCHK_EN
//   defined   - per-frame pixel counter; frame_err; res_valid suppressed on
//               bad frames
//   undefined - no counter; frame_err tied low; res_valid on every boundary
//
// Ports
//   clk, rst_n                     pixel clock, async active-low reset
//   cfg_valid/cfg_ready            host write handshake (ready only in IDLE)
//   cfg_addr, cfg_data             0 cb_min, 1 cb_max, 2 cr_min, 3 cr_max
//   cfg_commit                     apply shadow values at next frame boundary
//   de, hsync, vsync               sync signals at the bin stage input
//   cb_min..cr_max                 active thresholds to the bin stage
//   x_in, y_in / x_out, y_out      centroid in / latched per frame
//   res_valid                      one-cycle pulse on new x_out/y_out
//   frame_err                      last frame had the wrong pixel count
//   frame_cnt                      completed frames, wraps at 16 bits
//   busy                           commit pending or being applied
// -----------------------------------------------------------------------------
module frame_cfg_ctrl #(
    parameter int         IMG_W      = 64,
    parameter int         IMG_H      = 64,
    parameter logic [7:0] CB_MIN_RST = 8'd77,
    parameter logic [7:0] CB_MAX_RST = 8'd127,
    parameter logic [7:0] CR_MIN_RST = 8'd133,
    parameter logic [7:0] CR_MAX_RST = 8'd173
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    input  logic        cfg_commit,
    input  logic        de,
    input  logic        hsync,
    input  logic        vsync,
    output logic [7:0]  cb_min,
    output logic [7:0]  cb_max,
    output logic [7:0]  cr_min,
    output logic [7:0]  cr_max,
    input  logic [10:0] x_in,
    input  logic [10:0] y_in,
    output logic [10:0] x_out,
    output logic [10:0] y_out,
    output logic        res_valid,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int PIX_W = $clog2(NPIX + 1) + 1;
    localparam logic [PIX_W-1:0] PIX_TARGET = PIX_W'(NPIX);
    // Index 0 = cb_min ... index 3 = cr_max, matching cfg_addr.
    localparam logic [3:0][7:0] THR_RST = {CR_MAX_RST, CR_MIN_RST, CB_MAX_RST, CB_MIN_RST};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            vsync_d_q;
    logic [3:0][7:0] shadow_q, shadow_d;
    logic [3:0][7:0] active_q, active_d;
    logic [10:0]     x_out_q, x_out_d;
    logic [10:0]     y_out_q, y_out_d;
    logic            res_valid_q, res_valid_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            rise;
    logic            err_set;

`ifdef FRAME_CFG_CTRL_PIXCHK_EN
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d, pix_sum;
    logic             primed_q, primed_d;
    logic             frame_err_q, frame_err_d;
    logic             unused_inputs;
    assign unused_inputs = hsync;
`else
    logic             unused_inputs;
    assign unused_inputs = ^{hsync, de, PIX_TARGET};
`endif

    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = ~cfg_ready;

    always_comb begin
        rise        = vsync & ~vsync_d_q;
        state_d     = state_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        frame_cnt_d = frame_cnt_q;
        err_set     = 1'b0;

`ifdef FRAME_CFG_CTRL_PIXCHK_EN
        // de during the boundary cycle still belongs to the closing frame.
        pix_sum     = (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + PIX_W'(de);
        pix_cnt_d   = pix_sum;
        primed_d    = primed_q;
        frame_err_d = frame_err_q;
        if (rise) begin
            // The frame ending at the first boundary after reset is partial.
            err_set     = ~primed_q | (pix_sum != PIX_TARGET);
            frame_err_d = err_set;
            pix_cnt_d   = '0;
            primed_d    = 1'b1;
        end
`endif

        res_valid_d = rise & ~err_set;
        if (rise) begin
            x_out_d     = x_in;
            y_out_d     = y_in;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        // A write accepted together with a commit is part of that commit.
        if (cfg_valid && cfg_ready) begin
            shadow_d[cfg_addr] = cfg_data;
        end

        case (state_q)
            ST_IDLE:    if (cfg_commit) state_d = ST_PENDING;
            ST_PENDING: if (rise) state_d = ST_APPLY;
            ST_APPLY: begin
                active_d = shadow_q;
                state_d  = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vsync_d_q   <= 1'b1;
            shadow_q    <= THR_RST;
            active_q    <= THR_RST;
            x_out_q     <= '0;
            y_out_q     <= '0;
            res_valid_q <= 1'b0;
            frame_cnt_q <= '0;
`ifdef FRAME_CFG_CTRL_PIXCHK_EN
            pix_cnt_q   <= '0;
            primed_q    <= 1'b0;
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            vsync_d_q   <= vsync;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            res_valid_q <= res_valid_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef FRAME_CFG_CTRL_PIXCHK_EN
            pix_cnt_q   <= pix_cnt_d;
            primed_q    <= primed_d;
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign cb_min    = active_q[0];
    assign cb_max    = active_q[1];
    assign cr_min    = active_q[2];
    assign cr_max    = active_q[3];
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign res_valid = res_valid_q;
    assign frame_cnt = frame_cnt_q;
`ifdef FRAME_CFG_CTRL_PIXCHK_EN
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule
